board_scan: RTL and testbench

//  Reader side of the playfield storage written by the game-logic block. Walks the board row by row

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/scan_timer.sv | 28 ++
 rtl/board_scan.sv | 183 ++++++++++++++++++
 tb/tb_board_scan.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield dimensions, scan FSM states and a small sizing helper
// used by the board scanner.
package tetris_pkg;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 10;
  localparam int ROW_AW   = $clog2(ROWS_DEF);
  localparam int COL_W    = COLS_DEF;

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_REQ,
    SCAN_WAIT,
    SCAN_BLANK,
    SCAN_SHOW
  } scan_state_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that parks at zero; o_done flags the terminal count.
module scan_timer
  import tetris_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/board_scan.sv
// Reads playfield rows over a req/valid port and drives a row-multiplexed LED matrix.
// Optional SCAN_DIE_FLASH_EN adds an i_die input that inverts the columns on alternate frames.
module board_scan
  import tetris_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int DWELL   = 5000,
  parameter int BLANK   = 50,
  parameter int TIMEOUT = 15
) (
  input  logic                    i_clk,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_frame_lock,
`ifdef SCAN_DIE_FLASH_EN
  input  logic                    i_die,
`endif
  output logic                    o_rd_req,
  output logic [$clog2(ROWS)-1:0] o_rd_addr,
  input  logic [COLS-1:0]         i_rd_data,
  input  logic                    i_rd_vld,
  output logic [ROWS-1:0]         o_row_sel,
  output logic [COLS-1:0]         o_col_out,
  output logic                    o_frame_done,
  output logic                    o_rd_err
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(maxOf3(DWELL, BLANK, TIMEOUT) + 1);

  scan_state_t r_state, w_nextState;

  logic            r_rdReq, w_nextReq;
  logic [AW-1:0]   r_rdAddr, w_nextAddr;
  logic [ROWS-1:0] r_rowSel, w_nextRowSel;
  logic [COLS-1:0] r_colOut, w_nextColOut;
  logic [COLS-1:0] r_rowBuf, w_nextBuf;
  logic [COLS-1:0] w_showCols;
  logic            r_frameDone, w_nextFrameDone;
  logic            r_rdErr, w_nextErr;
  logic            w_tmrLoad, w_tmrDone;
  logic [CW-1:0]   w_tmrVal;

`ifdef SCAN_DIE_FLASH_EN
  logic r_invert, w_nextInvert;

  assign w_showCols = r_invert ? ~r_rowBuf : r_rowBuf;
`else
  assign w_showCols = r_rowBuf;
`endif

  // Phase lengths load as N-1 so the phase lasts exactly N cycles ending on the zero count.
  scan_timer #(.W(CW)) u_timer (
    .i_clk     (i_clk),
    .i_clr     (i_clr),
    .i_load    (w_tmrLoad),
    .i_loadVal (w_tmrVal),
    .o_done    (w_tmrDone)
  );

  always_comb begin
    w_nextState     = r_state;
    w_nextReq       = r_rdReq;
    w_nextAddr      = r_rdAddr;
    w_nextRowSel    = r_rowSel;
    w_nextColOut    = r_colOut;
    w_nextBuf       = r_rowBuf;
    w_nextFrameDone = 1'b0;
    w_nextErr       = r_rdErr;
    w_tmrLoad       = 1'b0;
    w_tmrVal        = '0;
`ifdef SCAN_DIE_FLASH_EN
    w_nextInvert    = r_invert;
`endif

    case (r_state)
      SCAN_IDLE: begin
        w_nextReq    = 1'b0;
        w_nextRowSel = '1;
        w_nextColOut = '0;
        if (i_en) begin
          w_nextState = SCAN_REQ;
          w_nextAddr  = '0;
        end
      end

      SCAN_REQ: begin
        if (!i_frame_lock) begin
          w_nextState = SCAN_WAIT;
          w_nextReq   = 1'b1;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CW'(TIMEOUT - 1);
        end
      end

      // Data beats a simultaneous timeout, so rd_vld is tested first.
      SCAN_WAIT: begin
        if (i_rd_vld) begin
          w_nextBuf   = i_rd_data;
          w_nextReq   = 1'b0;
          w_nextState = SCAN_BLANK;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CW'(BLANK - 1);
        end else if (w_tmrDone) begin
          w_nextBuf   = '0;
          w_nextErr   = 1'b1;
          w_nextReq   = 1'b0;
          w_nextState = SCAN_BLANK;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CW'(BLANK - 1);
        end
      end

      SCAN_BLANK: begin
        if (w_tmrDone) begin
          w_nextState  = SCAN_SHOW;
          w_nextRowSel = ~(ROWS'(1) << r_rdAddr);
          w_nextColOut = w_showCols;
          w_tmrLoad    = 1'b1;
          w_tmrVal     = CW'(DWELL - 1);
        end
      end

      SCAN_SHOW: begin
        if (w_tmrDone) begin
          w_nextRowSel = '1;
          w_nextColOut = '0;
          w_nextState  = i_en ? SCAN_REQ : SCAN_IDLE;
          if (r_rdAddr == AW'(ROWS - 1)) begin
            w_nextAddr      = '0;
            w_nextFrameDone = 1'b1;
`ifdef SCAN_DIE_FLASH_EN
            w_nextInvert    = i_die ? ~r_invert : 1'b0;
`endif
          end else begin
            w_nextAddr = r_rdAddr + 1'b1;
          end
        end
      end

      default: begin
        w_nextState = SCAN_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state     <= SCAN_IDLE;
      r_rdReq     <= 1'b0;
      r_rdAddr    <= '0;
      r_rowSel    <= '1;
      r_colOut    <= '0;
      r_rowBuf    <= '0;
      r_frameDone <= 1'b0;
      r_rdErr     <= 1'b0;
`ifdef SCAN_DIE_FLASH_EN
      r_invert    <= 1'b0;
`endif
    end else begin
      r_state     <= w_nextState;
      r_rdReq     <= w_nextReq;
      r_rdAddr    <= w_nextAddr;
      r_rowSel    <= w_nextRowSel;
      r_colOut    <= w_nextColOut;
      r_rowBuf    <= w_nextBuf;
      r_frameDone <= w_nextFrameDone;
      r_rdErr     <= w_nextErr;
`ifdef SCAN_DIE_FLASH_EN
      r_invert    <= w_nextInvert;
`endif
    end
  end

  assign o_rd_req     = r_rdReq;
  assign o_rd_addr    = r_rdAddr;
  assign o_row_sel    = r_rowSel;
  assign o_col_out    = r_colOut;
  assign o_frame_done = r_frameDone;
  assign o_rd_err     = r_rdErr;

endmodule

// File: tb/tb_board_scan.sv
// Scoreboard bench for board_scan: a read responder queues the expected lit rows,
// an independent monitor pops and checks them as the matrix lights up.
module tb_board_scan;

  localparam int ROWS    = 4;
  localparam int COLS    = 10;
  localparam int DWELL   = 4;
  localparam int BLANK   = 1;
  localparam int TIMEOUT = 3;

  typedef struct packed {
    logic [3:0] rowSel;
    logic [9:0] colOut;
  } rowExp_t;

  logic       clk       = 1'b0;
  logic       clr       = 1'b0;
  logic       en        = 1'b0;
  logic       frameLock = 1'b0;
  logic       rspVld    = 1'b0;
  logic       forceVld  = 1'b0;
  logic [9:0] rspData   = '0;
  logic       rdVld;
  logic [9:0] rdData;
  logic       rdReq;
  logic [1:0] rdAddr;
  logic [3:0] rowSel;
  logic [9:0] colOut;
  logic       frameDone;
  logic       rdErr;
`ifdef SCAN_DIE_FLASH_EN
  logic       die = 1'b0;
`endif

  int testsRun  = 0;
  int failCount = 0;

  rowExp_t expQ[$];
  int      lenQ[$];
  logic [9:0] rowData [4] = '{10'h3FF, 10'h001, 10'h200, 10'h155};
  bit skipArm = 1'b0;
  bit silent  = 1'b0;

  always #5 clk = ~clk;

  // A forced strobe carries a recognisable pattern that must never reach the matrix.
  assign rdVld  = rspVld | forceVld;
  assign rdData = forceVld ? 10'h2AA : rspData;

  board_scan #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_clr        (clr),
    .i_en         (en),
    .i_frame_lock (frameLock),
`ifdef SCAN_DIE_FLASH_EN
    .i_die        (die),
`endif
    .o_rd_req     (rdReq),
    .o_rd_addr    (rdAddr),
    .i_rd_data    (rdData),
    .i_rd_vld     (rdVld),
    .o_row_sel    (rowSel),
    .o_col_out    (colOut),
    .o_frame_done (frameDone),
    .o_rd_err     (rdErr)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic e, input logic l);
    clr       = c;
    en        = e;
    frameLock = l;
  endtask

  task automatic waitFrame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameDone && n < 200);
    checkOutput("frame_wait", int'(frameDone), 1);
  endtask

  // Responder: answers each new request one cycle later and queues what should light up.
  initial begin
    int expRow = 0;
    logic prevReq = 1'b0;
    bit skipUsed = 1'b0;
    logic [3:0] one = 4'b0001;
    rowExp_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        expRow = 0;
        prevReq = 1'b0;
        rspVld = 1'b0;
        skipUsed = 1'b0;
        expQ.delete();
        lenQ.delete();
      end else begin
        rspVld = 1'b0;
        if (!skipArm) skipUsed = 1'b0;
        if (rdReq && !prevReq && !silent) begin
          checkOutput("rd_addr", int'(rdAddr), expRow);
          e.rowSel = ~(one << expRow);
          if (skipArm && !skipUsed && expRow == 2) begin
            skipUsed = 1'b1;
            e.colOut = '0;
            lenQ.push_back(TIMEOUT);
          end else begin
            rspVld  = 1'b1;
            rspData = rowData[expRow];
            e.colOut = rowData[expRow];
            lenQ.push_back(1);
          end
          expQ.push_back(e);
          expRow = (expRow + 1) % ROWS;
        end
        prevReq = rdReq;
      end
    end
  end

  // Monitor: checks each lit row, its dwell, frame_done placement and request lengths.
  initial begin
    logic prevLit = 1'b0;
    logic lit;
    logic expFd;
    logic [3:0] prevRowSel = 4'b1111;
    int litCnt = 0;
    int reqLen = 0;
    rowExp_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        prevLit = 1'b0;
        prevRowSel = 4'b1111;
        litCnt = 0;
        reqLen = 0;
      end else begin
        lit = (rowSel != 4'b1111);
        if (lit && !prevLit) begin
          if (expQ.size() == 0) begin
            checkOutput("row_unexpected", int'(rowSel), 15);
          end else begin
            e = expQ.pop_front();
            checkOutput("row_sel", int'(rowSel), int'(e.rowSel));
            checkOutput("col_out", int'(colOut), int'(e.colOut));
          end
        end
        if (lit) litCnt++;
        if (!lit && prevLit) begin
          checkOutput("dwell", litCnt, DWELL);
          litCnt = 0;
        end
        expFd = !lit && prevLit && (prevRowSel == 4'b0111);
        if (expFd || frameDone) checkOutput("frame_done", int'(frameDone), int'(expFd));
        if (rdReq) begin
          reqLen++;
        end else if (reqLen > 0) begin
          if (lenQ.size() == 0) checkOutput("req_unexpected", reqLen, 0);
          else checkOutput("rd_req_len", reqLen, lenQ.pop_front());
          reqLen = 0;
        end
        prevLit = lit;
        prevRowSel = rowSel;
      end
    end
  end

  initial begin
    int n;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_row_sel", int'(rowSel), 15);
    checkOutput("reset_col_out", int'(colOut), 0);
    checkOutput("reset_rd_req", int'(rdReq), 0);
    checkOutput("reset_rd_err", int'(rdErr), 0);
    checkOutput("reset_frame_done", int'(frameDone), 0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    waitFrame();
    checkOutput("no_err_normal", int'(rdErr), 0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rowSel == 4'b1111 && n < 50);
    checkOutput("lit_wait", int'(rowSel != 4'b1111), 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("lock_rd_req", int'(rdReq), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lock_release_req", int'(rdReq), 1);
    waitFrame();

    skipArm = 1'b1;
    waitFrame();
    checkOutput("rd_err_sticky", int'(rdErr), 1);
    skipArm = 1'b0;
    waitFrame();
    checkOutput("rd_err_held", int'(rdErr), 1);

    silent = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdReq && n < 50);
    checkOutput("req_wait", int'(rdReq), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midreset_rd_req", int'(rdReq), 0);
    checkOutput("midreset_rd_addr", int'(rdAddr), 0);
    checkOutput("midreset_row_sel", int'(rowSel), 15);
    checkOutput("midreset_rd_err", int'(rdErr), 0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    forceVld = 1'b1;
    @(negedge clk);
    forceVld = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("late_vld_row_sel", int'(rowSel), 15);
    checkOutput("late_vld_rd_req", int'(rdReq), 0);
    silent = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitFrame();
    waitFrame();
    checkOutput("no_err_after_reset", int'(rdErr), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
